// File: rtl/sram_pixel_reader.sv
// Frame-buffer read side: fetches colour words from SRAM into a small FIFO
// and replays each word across PIX_PER_WORD active pixels.
module sram_pixel_reader #(
    parameter int COLS         = 100,
    parameter int ROWS         = 600,
    parameter int PIX_PER_WORD = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write,
    input  logic        frame_start,
    input  logic        pix_en,
    output logic [15:0] mem_addr,
    output logic        mem_oe,
    input  logic [5:0]  mem_data,
    output logic [5:0]  pix_rgb,
    output logic        underflow
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [15:0]   LINE_STEP = 16'(COLS);
    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PIX_LAST  = PW'(PIX_PER_WORD - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(READ_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PUSH
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [15:0]   base;
    logic [LW-1:0] lat;
    logic          oe_q;
    logic [15:0]   addr_q;
    logic [5:0]    word_q;

    logic [5:0]    fifo [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [PW-1:0] pcnt;
    logic [5:0]    pix_q;
    logic          under_q;

    logic push;
    logic pop;

    always_comb begin
        push = (state == S_PUSH);
        pop  = pix_en && (count != '0) && (pcnt == PIX_LAST);
    end

    // Gating here keeps the bus released the very cycle a write window opens.
    assign mem_oe    = oe_q & ~write;
    assign mem_addr  = addr_q;
    assign pix_rgb   = pix_q;
    assign underflow = under_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= word_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            col     <= '0;
            row     <= '0;
            base    <= '0;
            lat     <= '0;
            oe_q    <= 1'b0;
            addr_q  <= '0;
            word_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pcnt    <= '0;
            pix_q   <= '0;
            under_q <= 1'b0;
        end else if (frame_start) begin
            state   <= S_IDLE;
            col     <= '0;
            row     <= '0;
            base    <= '0;
            lat     <= '0;
            oe_q    <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pcnt    <= '0;
            pix_q   <= '0;
            under_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!write && count != FULL) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (write) begin
                        state <= S_IDLE;
                    end else begin
                        addr_q <= base + 16'(col);
                        oe_q   <= 1'b1;
                        lat    <= '0;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (write) begin
                        oe_q  <= 1'b0;
                        state <= S_IDLE;
                    end else if (lat == LAT_LAST) begin
                        word_q <= mem_data;
                        oe_q   <= 1'b0;
                        state  <= S_PUSH;
                    end else begin
                        lat <= lat + 1'b1;
                    end
                end
                S_PUSH: begin
                    oe_q  <= 1'b0;
                    state <= S_IDLE;
                    if (col == COL_LAST) begin
                        col <= '0;
                        if (row == ROW_LAST) begin
                            row  <= '0;
                            base <= '0;
                        end else begin
                            row  <= row + 1'b1;
                            base <= base + LINE_STEP;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);

            // An empty FIFO holds the pixel counter so the next word starts fresh.
            if (pix_en) begin
                if (count == '0) begin
                    pix_q   <= '0;
                    under_q <= 1'b1;
                end else begin
                    pix_q <= fifo[rd_ptr];
                    if (pcnt == PIX_LAST) begin
                        pcnt <= '0;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
            end else begin
                pix_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_pixel_reader.sv
// Bench for sram_pixel_reader: random SRAM contents, pixel-stream scoreboard
// and fetch-address monitor. ROWS is reduced so the frame wrap is reachable.
module tb_sram_pixel_reader;

    localparam int COLS  = 100;
    localparam int ROWS  = 8;
    localparam int PPW   = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int FRAME = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic        frame_start;
    logic        pix_en;
    logic [15:0] mem_addr;
    logic        mem_oe;
    logic [5:0]  mem_data;
    logic [5:0]  pix_rgb;
    logic        underflow;

    always #10 clk = ~clk;

    sram_pixel_reader #(
        .COLS(COLS),
        .ROWS(ROWS),
        .PIX_PER_WORD(PPW),
        .FIFO_DEPTH(DEPTH),
        .READ_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .write(write),
        .frame_start(frame_start),
        .pix_en(pix_en),
        .mem_addr(mem_addr),
        .mem_oe(mem_oe),
        .mem_data(mem_data),
        .pix_rgb(pix_rgb),
        .underflow(underflow)
    );

    // SRAM model: data is only valid once mem_oe has been high LAT cycles.
    logic [5:0] sram [FRAME];
    logic [5:0] rd_word;
    int         oe_age = 0;

    always @(posedge clk) oe_age <= mem_oe ? oe_age + 1 : 0;

    always_comb begin
        rd_word = 6'h00;
        if (int'(mem_addr) < FRAME) rd_word = sram[int'(mem_addr)];
    end

    assign mem_data = (mem_oe && oe_age >= LAT - 1) ? rd_word : ~rd_word;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] exp_q[$];
    int         widx = 0;
    int         pcnt_m = 0;
    bit         empty_mode = 0;

    int         exp_addr = 0;
    int         run = 0;
    logic       prev_oe = 1'b0;
    int         fetches = 0;
    int         aborts = 0;
    logic       pe_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and record the expected pixel for it.
    task automatic cyc(input bit w, input bit pe, input bit fs);
        @(posedge clk);
        #1;
        write       = w;
        pix_en      = pe;
        frame_start = fs;
        if (fs) begin
            widx   = 0;
            pcnt_m = 0;
        end
        if (pe) begin
            if (empty_mode) begin
                exp_q.push_back(6'h00);
            end else begin
                exp_q.push_back(sram[widx]);
                pcnt_m++;
                if (pcnt_m == PPW) begin
                    pcnt_m = 0;
                    widx   = (widx + 1) % FRAME;
                end
            end
        end
    endtask

    always @(posedge clk) pe_d <= pix_en;

    // Monitor: fetch addresses follow the linear frame order; a read counts
    // as complete only when mem_oe stayed high exactly LAT cycles.
    always @(negedge clk) begin
        if (rst) begin
            run      = 0;
            exp_addr = 0;
            prev_oe  = 1'b0;
        end else begin
            if (frame_start) begin
                run      = 0;
                exp_addr = 0;
            end else if (mem_oe) begin
                if (!prev_oe) chk("issue_addr", 32'(mem_addr), 32'(exp_addr));
                run++;
            end else begin
                if (run != 0) chk("oe_len_max", 32'(run <= LAT), 32'd1);
                if (run == LAT) begin
                    fetches++;
                    exp_addr = (exp_addr + 1) % FRAME;
                end else if (run > 0) begin
                    aborts++;
                end
                run = 0;
            end
            prev_oe = mem_oe;
            if (write) chk("oe_gated", 32'(mem_oe), 32'd0);
            if (pe_d) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_queue: got %0h expected nothing", pix_rgb);
                end else begin
                    chk("pix", 32'(pix_rgb), 32'(exp_q.pop_front()));
                end
            end else begin
                chk("pix_idle", 32'(pix_rgb), 32'd0);
            end
        end
    end

    initial begin
        bit         seen;
        logic [15:0] a_addr;
        int         ab;

        rst         = 1'b1;
        write       = 1'b1;
        pix_en      = 1'b0;
        frame_start = 1'b0;
        for (int i = 0; i < FRAME; i++) sram[i] = 6'($urandom);
        sram[0] = 6'h2A;
        sram[1] = 6'h01;
        sram[2] = 6'h02;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_oe", 32'(mem_oe), 32'd0);
        chk("rst_pix", 32'(pix_rgb), 32'd0);
        chk("rst_under", 32'(underflow), 32'd0);
        rst = 1'b0;

        // Fill: exactly DEPTH fetches, then the bus stays idle.
        repeat (40) cyc(0, 0, 0);
        @(negedge clk);
        chk("fill_fetches", 32'(fetches), 32'(DEPTH));
        chk("fill_aborts", 32'(aborts), 32'd0);
        chk("fill_oe_idle", 32'(mem_oe), 32'd0);

        // Replay: each word held for PPW pixels.
        repeat (24) cyc(0, 1, 0);
        repeat (2) cyc(0, 0, 0);
        @(negedge clk);
        chk("replay_under", 32'(underflow), 32'd0);

        // Abort a fetch by raising write during its latency window.
        repeat (20) cyc(0, 0, 0);
        repeat (8) cyc(1, 1, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(0, 0, 0);
            @(negedge clk);
            if (mem_oe) seen = 1;
        end
        chk("abort_seen", 32'(seen), 32'd1);
        if (seen) begin
            a_addr = mem_addr;
            ab     = aborts;
            cyc(1, 0, 0);
            @(negedge clk);
            chk("abort_oe", 32'(mem_oe), 32'd0);
            repeat (3) cyc(1, 0, 0);
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                cyc(0, 0, 0);
                @(negedge clk);
                if (mem_oe) seen = 1;
            end
            chk("reissue_seen", 32'(seen), 32'd1);
            chk("reissue_addr", 32'(mem_addr), 32'(a_addr));
            chk("abort_count", 32'(aborts), 32'(ab + 1));
        end

        // Underflow on an empty FIFO, cleared by frame_start.
        cyc(1, 0, 1);
        repeat (2) cyc(1, 0, 0);
        empty_mode = 1;
        repeat (3) cyc(1, 1, 0);
        cyc(1, 0, 0);
        empty_mode = 0;
        @(negedge clk);
        chk("underflow_set", 32'(underflow), 32'd1);
        cyc(1, 0, 1);
        cyc(1, 0, 0);
        @(negedge clk);
        chk("underflow_clr", 32'(underflow), 32'd0);

        // Random blanking/active segments, long enough to wrap the frame.
        for (int s = 0; s < 16; s++) begin
            repeat (15) cyc(1'($urandom_range(0, 1)), 0, 0);
            repeat (25) cyc(0, 0, 0);
            repeat (600) cyc(0, $urandom_range(0, 7) != 0, 0);
        end
        repeat (3) cyc(0, 0, 0);
        @(negedge clk);
        chk("run_under", 32'(underflow), 32'd0);
        chk("run_drained", 32'(exp_q.size()), 32'd0);
        chk("run_wrapped", 32'(fetches > FRAME), 32'd1);

        // Mid-operation reset returns straight to reset values.
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_oe", 32'(mem_oe), 32'd0);
        chk("mid_rst_pix", 32'(pix_rgb), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        widx   = 0;
        pcnt_m = 0;
        repeat (25) cyc(0, 0, 0);
        repeat (24) cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 0);
        @(negedge clk);
        chk("post_rst_drained", 32'(exp_q.size()), 32'd0);
        chk("post_rst_under", 32'(underflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
